vn_lut_port_sched: RTL and testbench

//  Round-robin scheduler sharing one dual-port (A/B) decomposed VN LUT among REQ_NUM VNU requesters.

---
 rtl/vn_lut_port_sched.sv | 196 +++++++++++++++++++
 tb/tb_vn_lut_port_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vn_lut_port_sched.sv
// vn_lut_port_sched: round-robin scheduler sharing one dual-port VN LUT among REQ_NUM requesters.
// Grants up to two reads per cycle (port A then port B) and routes LUT data back by tag.
module vn_lut_port_sched #(
  parameter int REQ_NUM = 4,
  parameter int Y0_W    = 2,
  parameter int Y1_W    = 3,
  parameter int PAGE_W  = 5,
  parameter int DATA_W  = 3,
  parameter int LUT_LAT = 1
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      sched_en,
  input  logic [REQ_NUM-1:0]        req_valid,
  input  logic [REQ_NUM*Y0_W-1:0]   req_y0,
  input  logic [REQ_NUM*Y1_W-1:0]   req_y1,
  output logic [REQ_NUM-1:0]        req_ready,
  output logic                      ren_A,
  output logic [PAGE_W-1:0]         page_addr_A,
  output logic                      ren_B,
  output logic [PAGE_W-1:0]         page_addr_B,
  input  logic [DATA_W-1:0]         lut_dout_A,
  input  logic [DATA_W-1:0]         lut_dout_B,
  output logic [REQ_NUM-1:0]        rsp_valid,
  output logic [REQ_NUM*DATA_W-1:0] rsp_data,
  output logic                      busy
);

  localparam int            IW          = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [IW:0]   REQ_NUM_EXT = (IW+1)'(REQ_NUM);
  localparam logic [IW-1:0] LAST_IDX    = IW'(REQ_NUM - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                    state_r;
  logic [IW-1:0]             rr_ptr_r;
  logic [IW-1:0]             iss_idx_a_r;
  logic [IW-1:0]             iss_idx_b_r;
  logic                      tag_a_v_r   [LUT_LAT];
  logic [IW-1:0]             tag_a_idx_r [LUT_LAT];
  logic                      tag_b_v_r   [LUT_LAT];
  logic [IW-1:0]             tag_b_idx_r [LUT_LAT];

  logic [REQ_NUM-1:0]        gnt_vec_s;
  logic                      gnt_a_s;
  logic                      gnt_b_s;
  logic [IW-1:0]             gnt_a_idx_s;
  logic [IW-1:0]             gnt_b_idx_s;
  logic [IW:0]               scan_sum_s;
  logic [IW-1:0]             scan_idx_s;
  logic                      inflight_s;
  logic [REQ_NUM-1:0]        rsp_valid_nxt_s;
  logic [REQ_NUM*DATA_W-1:0] rsp_data_nxt_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    logic [IW-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + IW'(1);
    end
    return nxt;
  endfunction

  // Circular scan from rr_ptr_r: first valid requester takes port A, second takes port B
  always_comb begin
    gnt_vec_s   = '0;
    gnt_a_s     = 1'b0;
    gnt_b_s     = 1'b0;
    gnt_a_idx_s = '0;
    gnt_b_idx_s = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    if ((state_r == RUN) && sched_en) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        scan_sum_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
        if (scan_sum_s >= REQ_NUM_EXT) begin
          scan_sum_s = scan_sum_s - REQ_NUM_EXT;
        end else begin
          scan_sum_s = scan_sum_s;
        end
        scan_idx_s = scan_sum_s[IW-1:0];
        if (req_valid[scan_idx_s] && !gnt_a_s) begin
          gnt_a_s               = 1'b1;
          gnt_a_idx_s           = scan_idx_s;
          gnt_vec_s[scan_idx_s] = 1'b1;
        end else if (req_valid[scan_idx_s] && !gnt_b_s) begin
          gnt_b_s               = 1'b1;
          gnt_b_idx_s           = scan_idx_s;
          gnt_vec_s[scan_idx_s] = 1'b1;
        end else begin
          gnt_vec_s = gnt_vec_s;
        end
      end
    end else begin
      gnt_vec_s = '0;
    end
  end

  assign req_ready = gnt_vec_s;
  assign busy      = (state_r != IDLE);

  // A read counts as in flight from issue until its response strobe has been shown
  always_comb begin
    inflight_s = ren_A | ren_B | (|rsp_valid);
    for (int k = 0; k < LUT_LAT; k++) begin
      inflight_s = inflight_s | tag_a_v_r[k] | tag_b_v_r[k];
    end
  end

  // Route the LUT data of each port to the requester named by its oldest tag
  always_comb begin
    rsp_valid_nxt_s = '0;
    rsp_data_nxt_s  = rsp_data;
    if (tag_a_v_r[LUT_LAT-1]) begin
      rsp_valid_nxt_s[tag_a_idx_r[LUT_LAT-1]]                       = 1'b1;
      rsp_data_nxt_s[int'(tag_a_idx_r[LUT_LAT-1])*DATA_W +: DATA_W] = lut_dout_A;
    end else begin
      rsp_data_nxt_s = rsp_data_nxt_s;
    end
    if (tag_b_v_r[LUT_LAT-1]) begin
      rsp_valid_nxt_s[tag_b_idx_r[LUT_LAT-1]]                       = 1'b1;
      rsp_data_nxt_s[int'(tag_b_idx_r[LUT_LAT-1])*DATA_W +: DATA_W] = lut_dout_B;
    end else begin
      rsp_data_nxt_s = rsp_data_nxt_s;
    end
  end

  // Scheduler state, pointer, issue registers, tag pipeline and response stage
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      ren_A       <= 1'b0;
      ren_B       <= 1'b0;
      page_addr_A <= '0;
      page_addr_B <= '0;
      iss_idx_a_r <= '0;
      iss_idx_b_r <= '0;
      for (int k = 0; k < LUT_LAT; k++) begin
        tag_a_v_r[k]   <= 1'b0;
        tag_a_idx_r[k] <= '0;
        tag_b_v_r[k]   <= 1'b0;
        tag_b_idx_r[k] <= '0;
      end
      rsp_valid   <= '0;
      rsp_data    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sched_en) state_r <= RUN;
        end
        RUN: begin
          if (!sched_en) state_r <= inflight_s ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (sched_en) state_r <= RUN;
          else if (!inflight_s) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase

      if (gnt_b_s) rr_ptr_r <= next_idx(gnt_b_idx_s);
      else if (gnt_a_s) rr_ptr_r <= next_idx(gnt_a_idx_s);

      // Page addresses hold their last value between issues
      ren_A       <= gnt_a_s;
      ren_B       <= gnt_b_s;
      iss_idx_a_r <= gnt_a_idx_s;
      iss_idx_b_r <= gnt_b_idx_s;
      if (gnt_a_s) begin
        page_addr_A <= PAGE_W'({req_y0[int'(gnt_a_idx_s)*Y0_W +: Y0_W],
                                req_y1[int'(gnt_a_idx_s)*Y1_W +: Y1_W]});
      end
      if (gnt_b_s) begin
        page_addr_B <= PAGE_W'({req_y0[int'(gnt_b_idx_s)*Y0_W +: Y0_W],
                                req_y1[int'(gnt_b_idx_s)*Y1_W +: Y1_W]});
      end

      tag_a_v_r[0]   <= ren_A;
      tag_a_idx_r[0] <= iss_idx_a_r;
      tag_b_v_r[0]   <= ren_B;
      tag_b_idx_r[0] <= iss_idx_b_r;
      for (int k = 1; k < LUT_LAT; k++) begin
        tag_a_v_r[k]   <= tag_a_v_r[k-1];
        tag_a_idx_r[k] <= tag_a_idx_r[k-1];
        tag_b_v_r[k]   <= tag_b_v_r[k-1];
        tag_b_idx_r[k] <= tag_b_idx_r[k-1];
      end

      rsp_valid <= rsp_valid_nxt_s;
      rsp_data  <= rsp_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_vn_lut_port_sched.sv
// tb_vn_lut_port_sched: table vectors, random traffic against a scoreboard model,
// and directed reset / drain sequences for vn_lut_port_sched.
module tb_vn_lut_port_sched;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [3:0]  req_valid;
  logic [7:0]  req_y0;
  logic [11:0] req_y1;
  logic [3:0]  req_ready;
  logic        ren_A, ren_B;
  logic [4:0]  page_addr_A, page_addr_B;
  logic [2:0]  lut_dout_A, lut_dout_B;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic        busy;

  int passed = 0;
  int total  = 0;

  vn_lut_port_sched #(.REQ_NUM(4), .Y0_W(2), .Y1_W(3), .PAGE_W(5), .DATA_W(3), .LUT_LAT(LAT)) dut (
    .sys_clk(sys_clk), .rst(rst), .sched_en(sched_en), .req_valid(req_valid),
    .req_y0(req_y0), .req_y1(req_y1), .req_ready(req_ready),
    .ren_A(ren_A), .page_addr_A(page_addr_A), .ren_B(ren_B), .page_addr_B(page_addr_B),
    .lut_dout_A(lut_dout_A), .lut_dout_B(lut_dout_B),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected bench to finish");
    $fatal(1);
  end

  // Scoreboard: expectations scheduled into an 8-entry ring keyed by cycle number
  int         rr_m;
  logic       prev_en_m;
  int         cyc;
  logic       r_ren_a [8];
  logic       r_ren_b [8];
  logic [4:0] r_addr_a [8];
  logic [4:0] r_addr_b [8];
  logic [3:0] r_rsp_v [8];
  logic [2:0] r_rsp_d [8][4];
  logic [4:0] held_a_m, held_b_m;
  logic [2:0] data_m [4];
  logic [4:0] hist_a, hist_b;

  function automatic logic [2:0] lut_f(input logic [4:0] a);
    logic [7:0] t;
    t = {3'b000, a} * 8'd5 + 8'd3;
    return t[2:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_slot(input int s);
    r_ren_a[s]  = 1'b0;
    r_ren_b[s]  = 1'b0;
    r_addr_a[s] = 5'd0;
    r_addr_b[s] = 5'd0;
    r_rsp_v[s]  = 4'd0;
    for (int i = 0; i < N; i++) r_rsp_d[s][i] = 3'd0;
  endtask

  task automatic model_reset();
    rr_m      = 0;
    prev_en_m = 1'b0;
    held_a_m  = 5'd0;
    held_b_m  = 5'd0;
    hist_a    = 5'd0;
    hist_b    = 5'd0;
    for (int s = 0; s < 8; s++) clear_slot(s);
    for (int i = 0; i < N; i++) data_m[i] = 3'd0;
  endtask

  // One cycle: drive at posedge+1, predict, check at negedge, return at next posedge+1
  task automatic step(input logic en, input logic [3:0] v, input logic [7:0] y0,
                      input logic [11:0] y1, output logic [3:0] rdy,
                      output logic bsy, output logic [3:0] rv);
    int         g [2];
    int         cnt;
    int         j;
    int         s;
    logic [3:0] exp_rdy;
    logic [4:0] pa;
    logic [11:0] exp_d;
    sched_en   = en;
    req_valid  = v;
    req_y0     = y0;
    req_y1     = y1;
    lut_dout_A = lut_f(hist_a);
    lut_dout_B = lut_f(hist_b);
    cnt        = 0;
    exp_rdy    = 4'd0;
    // granting happens only when enable was also high last cycle (scheduler running)
    if (en && prev_en_m) begin
      for (int k = 0; k < N; k++) begin
        j = (rr_m + k) % N;
        if (v[j] && cnt < 2) begin
          g[cnt]     = j;
          cnt++;
          exp_rdy[j] = 1'b1;
        end
      end
    end
    prev_en_m = en;
    if (cnt > 0) rr_m = (g[cnt-1] + 1) % N;
    for (int p = 0; p < cnt; p++) begin
      pa = {y0[g[p]*2 +: 2], y1[g[p]*3 +: 3]};
      s  = (cyc + 1) % 8;
      if (p == 0) begin
        r_ren_a[s]  = 1'b1;
        r_addr_a[s] = pa;
      end else begin
        r_ren_b[s]  = 1'b1;
        r_addr_b[s] = pa;
      end
      s = (cyc + 2 + LAT) % 8;
      r_rsp_v[s][g[p]] = 1'b1;
      r_rsp_d[s][g[p]] = lut_f(pa);
    end
    s = cyc % 8;
    if (r_ren_a[s]) held_a_m = r_addr_a[s];
    if (r_ren_b[s]) held_b_m = r_addr_b[s];
    for (int i = 0; i < N; i++) if (r_rsp_v[s][i]) data_m[i] = r_rsp_d[s][i];
    exp_d = {data_m[3], data_m[2], data_m[1], data_m[0]};
    @(negedge sys_clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("ren_A", 32'(ren_A), 32'(r_ren_a[s]));
    chk("page_addr_A", 32'(page_addr_A), 32'(held_a_m));
    chk("ren_B", 32'(ren_B), 32'(r_ren_b[s]));
    chk("page_addr_B", 32'(page_addr_B), 32'(held_b_m));
    chk("rsp_valid", 32'(rsp_valid), 32'(r_rsp_v[s]));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    rdy    = req_ready;
    bsy    = busy;
    rv     = rsp_valid;
    hist_a = page_addr_A;
    hist_b = page_addr_B;
    clear_slot(s);
    cyc++;
    @(posedge sys_clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  v;
    logic [7:0]  y0;
    logic [11:0] y1;
    logic [3:0]  exp_rdy;
  } vec_t;

  initial begin
    vec_t       tbl [12];
    logic [3:0] rdy, rv;
    logic       bsy;
    logic [3:0] any_rsp;

    tbl[0]  = '{1'b1, 4'b1111, 8'hE4, 12'h5A3, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0100, 8'h20, 12'h0C0, 4'b0100};
    tbl[2]  = '{1'b1, 4'b1111, 8'hE4, 12'h5A3, 4'b1001};
    tbl[3]  = '{1'b1, 4'b1111, 8'h1B, 12'hA5C, 4'b0110};
    tbl[4]  = '{1'b1, 4'b0000, 8'hE4, 12'h5A3, 4'b0000};
    tbl[5]  = '{1'b1, 4'b1001, 8'h72, 12'h3D1, 4'b1001};
    tbl[6]  = '{1'b1, 4'b0001, 8'hE4, 12'h5A3, 4'b0001};
    tbl[7]  = '{1'b1, 4'b1010, 8'h9C, 12'hF06, 4'b1010};
    tbl[8]  = '{1'b1, 4'b1111, 8'hE4, 12'h5A3, 4'b0011};
    tbl[9]  = '{1'b1, 4'b1111, 8'h36, 12'h8E7, 4'b1100};
    tbl[10] = '{1'b1, 4'b1111, 8'hE4, 12'h5A3, 4'b0011};
    tbl[11] = '{1'b1, 4'b1111, 8'hC9, 12'h14B, 4'b1100};

    cyc        = 0;
    rst        = 1'b1;
    sched_en   = 1'b1;
    req_valid  = 4'b1111;
    req_y0     = 8'hFF;
    req_y1     = 12'hFFF;
    lut_dout_A = 3'd0;
    lut_dout_B = 3'd0;
    model_reset();

    // reset with every requester asserting
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("t1_req_ready", 32'(req_ready), 32'd0);
    chk("t1_ren_A", 32'(ren_A), 32'd0);
    chk("t1_ren_B", 32'(ren_B), 32'd0);
    chk("t1_page_addr_A", 32'(page_addr_A), 32'd0);
    chk("t1_page_addr_B", 32'(page_addr_B), 32'd0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_rsp_data", 32'(rsp_data), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'b1111, 8'hFF, 12'hFFF, rdy, bsy, rv);
      chk("t1_no_grant", 32'(rdy), 32'd0);
    end

    // table vectors: IDLE entry, single request, round-robin and wrap patterns
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].y0, tbl[i].y1, rdy, bsy, rv);
      chk("tbl_ready", 32'(rdy), 32'(tbl[i].exp_rdy));
      if (i == 1) begin
        chk("t2_page_addr_A", 32'(page_addr_A), 32'(5'b10011));
        chk("t2_ren_B", 32'(ren_B), 32'd0);
      end
    end

    // random traffic with occasional enable drops
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, 4'($urandom), 8'($urandom),
           12'($urandom), rdy, bsy, rv);
    end

    // drain: two reads in flight when enable drops
    step(1'b1, 4'b0000, 8'h00, 12'h000, rdy, bsy, rv);
    step(1'b1, 4'b1111, 8'h5A, 12'hC3F, rdy, bsy, rv);
    chk("t5_two_grants", 32'($countones(rdy)), 32'd2);
    step(1'b0, 4'b1111, 8'h00, 12'h000, rdy, bsy, rv);
    step(1'b0, 4'b1111, 8'h00, 12'h000, rdy, bsy, rv);
    chk("t5_drain_ready", 32'(rdy), 32'd0);
    chk("t5_drain_busy", 32'(bsy), 32'd1);
    step(1'b0, 4'b0000, 8'h00, 12'h000, rdy, bsy, rv);
    chk("t5_rsp_count", 32'($countones(rv)), 32'd2);
    chk("t5_busy_at_rsp", 32'(bsy), 32'd1);
    for (int i = 0; i < 8 && bsy; i++) begin
      step(1'b0, 4'b0000, 8'h00, 12'h000, rdy, bsy, rv);
    end
    chk("t5_idle", 32'(bsy), 32'd0);

    // reset one cycle after a grant: its responses must never appear
    step(1'b1, 4'b0000, 8'h00, 12'h000, rdy, bsy, rv);
    step(1'b1, 4'b0101, 8'hB7, 12'h2D9, rdy, bsy, rv);
    chk("t6_grant", 32'(rdy), 32'(4'b0101));
    rst = 1'b1;
    @(negedge sys_clk);
    chk("t6_ren_A_in_reset", 32'(ren_A), 32'd0);
    chk("t6_busy_in_reset", 32'(busy), 32'd0);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    model_reset();
    any_rsp = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0000, 8'h00, 12'h000, rdy, bsy, rv);
      any_rsp = any_rsp | rv;
    end
    chk("t6_no_rsp", 32'(any_rsp), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
